// File: rtl/mult4_arbiter.sv
//==============================================================================
// Module  : mult4_arbiter
// Brief   : Round-robin two-port sequencer for one shared signed 4x4 multiplier
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module signed_mult4_flags (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] result_o,
   output logic       zero_o,
   output logic       negative_o,
   output logic       carry_o,
   output logic       overflow_o
);
   logic [7:0] a_ext;
   logic [7:0] b_ext;

   // The low 8 bits of a sign-extended product equal the signed product.
   assign a_ext      = {{4{a_i[3]}}, a_i};
   assign b_ext      = {{4{b_i[3]}}, b_i};
   assign result_o   = a_ext * b_ext;
   assign zero_o     = (result_o == 8'h00);
   assign negative_o = result_o[7];
   assign carry_o    = (result_o[7:4] != {4{result_o[3]}});
   assign overflow_o = carry_o;
endmodule

module mult4_arbiter #(
   parameter int unsigned FIRST_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       req1_ready,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_result,
   output logic       rsp_zero,
   output logic       rsp_negative,
   output logic       rsp_carry,
   output logic       rsp_overflow,
   output logic       busy,
   output logic [7:0] op_count
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic PRIO_RST = 1'(FIRST_PRIO);

   state_t     state_q;
   logic       prio_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       id_q;
   logic       rsp_valid_q;
   logic       rsp_id_q;
   logic [7:0] rsp_result_q;
   logic       rsp_zero_q;
   logic       rsp_negative_q;
   logic       rsp_carry_q;
   logic       rsp_overflow_q;
   logic [7:0] op_count_q;

   logic       grant0;
   logic       grant1;
   logic [7:0] mul_result;
   logic       mul_zero;
   logic       mul_negative;
   logic       mul_carry;
   logic       mul_overflow;

   // A lone requester always wins; on contention the priority holder wins.
   assign grant0     = req0_valid && (!req1_valid || (prio_q == 1'b0));
   assign grant1     = req1_valid && (!req0_valid || (prio_q == 1'b1));
   assign req0_ready = (state_q == IDLE) && grant0;
   assign req1_ready = (state_q == IDLE) && grant1;

   signed_mult4_flags u_mult (
      .a_i        (a_q),
      .b_i        (b_q),
      .result_o   (mul_result),
      .zero_o     (mul_zero),
      .negative_o (mul_negative),
      .carry_o    (mul_carry),
      .overflow_o (mul_overflow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         prio_q         <= PRIO_RST;
         a_q            <= 4'h0;
         b_q            <= 4'h0;
         id_q           <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= 1'b0;
         rsp_result_q   <= 8'h00;
         rsp_zero_q     <= 1'b0;
         rsp_negative_q <= 1'b0;
         rsp_carry_q    <= 1'b0;
         rsp_overflow_q <= 1'b0;
         op_count_q     <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0_valid && req0_ready) begin
                  a_q     <= req0_a;
                  b_q     <= req0_b;
                  id_q    <= 1'b0;
                  state_q <= CALC;
               end else if (req1_valid && req1_ready) begin
                  a_q     <= req1_a;
                  b_q     <= req1_b;
                  id_q    <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               rsp_result_q   <= mul_result;
               rsp_zero_q     <= mul_zero;
               rsp_negative_q <= mul_negative;
               rsp_carry_q    <= mul_carry;
               rsp_overflow_q <= mul_overflow;
               rsp_id_q       <= id_q;
               rsp_valid_q    <= 1'b1;
               state_q        <= RESP;
            end
            RESP: begin
               // Priority passes to whoever was not served.
               if (rsp_valid_q && rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  prio_q      <= ~rsp_id_q;
                  op_count_q  <= op_count_q + 8'd1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_negative = rsp_negative_q;
   assign rsp_carry    = rsp_carry_q;
   assign rsp_overflow = rsp_overflow_q;
   assign busy         = (state_q != IDLE);
   assign op_count     = op_count_q;
endmodule

`default_nettype wire

// File: tb/tb_mult4_arbiter.sv
//==============================================================================
// Module  : tb_mult4_arbiter
// Brief   : Directed self-checking bench for mult4_arbiter
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mult4_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [3:0] req0_a = 4'h0;
   logic [3:0] req0_b = 4'h0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [3:0] req1_a = 4'h0;
   logic [3:0] req1_b = 4'h0;
   logic       req1_ready;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic       rsp_id;
   logic [7:0] rsp_result;
   logic       rsp_zero;
   logic       rsp_negative;
   logic       rsp_carry;
   logic       rsp_overflow;
   logic       busy;
   logic [7:0] op_count;

   int passed = 0;
   int total  = 0;

   mult4_arbiter #(.FIRST_PRIO(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .req1_ready   (req1_ready),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_negative (rsp_negative),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .busy         (busy),
      .op_count     (op_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_rsp(input string tag, input logic id, input logic [7:0] res,
                          input logic z, input logic n, input logic c);
      chk1({tag, "_valid"}, rsp_valid, 1'b1);
      chk1({tag, "_id"}, rsp_id, id);
      chk8({tag, "_result"}, rsp_result, res);
      chk1({tag, "_zero"}, rsp_zero, z);
      chk1({tag, "_neg"}, rsp_negative, n);
      chk1({tag, "_carry"}, rsp_carry, c);
      chk1({tag, "_ovf"}, rsp_overflow, c);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_op_count", op_count, 8'h00);
      chk8("rst_result", rsp_result, 8'h00);
      chk1("rst_id", rsp_id, 1'b0);
      chk1("rst_ready0", req0_ready, 1'b0);
      rst = 1'b0;

      // 1: req0 alone, 3 * -2 = -6
      req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'hE;
      #1;
      chk1("t1_ready0", req0_ready, 1'b1);
      chk1("t1_ready1", req1_ready, 1'b0);
      tick();
      req0_valid = 1'b0;
      chk1("t1_calc_busy", busy, 1'b1);
      chk1("t1_calc_ready0", req0_ready, 1'b0);
      chk1("t1_calc_rsp_valid", rsp_valid, 1'b0);
      tick();
      chk_rsp("t1", 1'b0, 8'hFA, 1'b0, 1'b1, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1("t1_done_valid", rsp_valid, 1'b0);
      chk8("t1_op_count", op_count, 8'h01);
      chk1("t1_done_busy", busy, 1'b0);

      // 2: both valid from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 4'h8; req0_b = 4'h8;
      req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h7;
      rsp_ready  = 1'b1;
      #1;
      chk1("t2_ready0", req0_ready, 1'b1);
      chk1("t2_ready1", req1_ready, 1'b0);
      tick();
      tick();
      chk_rsp("t2a", 1'b0, 8'h40, 1'b0, 1'b0, 1'b1);
      tick();
      chk8("t2a_op_count", op_count, 8'h01);
      chk1("t2b_ready0", req0_ready, 1'b0);
      chk1("t2b_ready1", req1_ready, 1'b1);
      tick();
      tick();
      chk_rsp("t2b", 1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
      tick();
      chk8("t2b_op_count", op_count, 8'h02);

      // 3: backpressure with both valids high
      rsp_ready = 1'b0;
      tick();
      tick();
      chk_rsp("t3", 1'b0, 8'h40, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk8("t3_hold_result", rsp_result, 8'h40);
         chk1("t3_hold_valid", rsp_valid, 1'b1);
         chk1("t3_hold_id", rsp_id, 1'b0);
         chk1("t3_hold_ready0", req0_ready, 1'b0);
         chk1("t3_hold_ready1", req1_ready, 1'b0);
         chk1("t3_hold_busy", busy, 1'b1);
      end
      chk8("t3_hold_count", op_count, 8'h02);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1("t3_rel_valid", rsp_valid, 1'b0);
      chk8("t3_rel_count", op_count, 8'h03);
      tick();
      chk8("t3_once_count", op_count, 8'h03);
      tick();
      chk_rsp("t3b", 1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk8("t3b_count", op_count, 8'h04);

      // 4: zero product, 0 * -5
      req1_valid = 1'b1; req1_a = 4'h0; req1_b = 4'hB;
      #1;
      chk1("t4_ready1", req1_ready, 1'b1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk_rsp("t4", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk8("t4_count", op_count, 8'h05);

      // req0 once more (2 * -1) so priority moves to requester 1
      req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'hF;
      tick();
      req0_valid = 1'b0;
      tick();
      chk_rsp("t4b", 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk8("t4b_count", op_count, 8'h06);

      // 5: async reset while req1's operation is in CALC
      req1_valid = 1'b1; req1_a = 4'h3; req1_b = 4'h3;
      tick();
      req1_valid = 1'b0;
      chk1("t5_calc_busy", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("t5_async_valid", rsp_valid, 1'b0);
      chk1("t5_async_busy", busy, 1'b0);
      chk8("t5_async_count", op_count, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk1("t5_no_rsp", rsp_valid, 1'b0);
      chk1("t5_idle", busy, 1'b0);
      req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1;
      req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2;
      #1;
      chk1("t5_prio_ready0", req0_ready, 1'b1);
      chk1("t5_prio_ready1", req1_ready, 1'b0);

      // 6: strict alternation, then wrap of op_count
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tick();
         chk1("t6_valid", rsp_valid, 1'b1);
         chk1("t6_id", rsp_id, i[0]);
         tick();
      end
      chk8("t6_count4", op_count, 8'h04);
      for (int i = 0; i < 251; i++) begin
         tick();
         tick();
         tick();
      end
      chk8("t6_count255", op_count, 8'hFF);
      tick();
      tick();
      tick();
      chk8("t6_wrap", op_count, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

`default_nettype wire
